// File: rtl/mono_hit_proc.sv
// mono_hit_proc: ToT post-processing of MONOPIX hit words
// Threshold filter, hit/drop counters, small FWFT output FIFO
module mono_hit_proc #(
    parameter int OUT_DEPTH = 8,
    parameter int ABUSWIDTH = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    input  logic                 BUS_WR,
    input  logic                 BUS_RD,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic [31:0]          IN_DATA,
    input  logic                 IN_EMPTY,
    output logic                 IN_READ,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_EMPTY,
    input  logic                 OUT_READ
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int OW = AW + 1;

    localparam logic [ABUSWIDTH-1:0] A_VER  = ABUSWIDTH'(0);
    localparam logic [ABUSWIDTH-1:0] A_CONF = ABUSWIDTH'(2);
    localparam logic [ABUSWIDTH-1:0] A_TOT  = ABUSWIDTH'(3);
    localparam logic [ABUSWIDTH-1:0] A_HITL = ABUSWIDTH'(4);
    localparam logic [ABUSWIDTH-1:0] A_HITH = ABUSWIDTH'(5);
    localparam logic [ABUSWIDTH-1:0] A_DROP = ABUSWIDTH'(6);

    localparam logic [7:0] VERSION = 8'd1;

    logic           rst;
    logic           conf_en;
    logic           conf_bypass;
    logic [7:0]     conf_tot_min;
    logic [15:0]    hit_cnt;
    logic [7:0]     drop_cnt;
    logic [7:0]     rd_mux;

    logic [31:0]    s1;
    logic           s1_valid;
    logic [7:0]     tot;
    logic [31:0]    out_word;
    logic [31:0]    wr_word;
    logic           keep;
    logic           fifo_wr;
    logic           fifo_rd;
    logic           drop;

    logic [31:0]    mem [OUT_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [OW-1:0]  occ;

    // a write to address 0 acts as a soft reset
    assign rst = BUS_RST | (BUS_WR && (BUS_ADD == A_VER));

    // pop only when the word already in flight still has a free slot too
    assign IN_READ = !rst && conf_en && !IN_EMPTY &&
                     ((occ + OW'(s1_valid)) < OW'(OUT_DEPTH));

    assign tot      = s1[21:14] - s1[29:22];
    assign out_word = {s1[31:22], tot, s1[13:0]};
    assign keep     = conf_bypass || (tot >= conf_tot_min);
    assign wr_word  = conf_bypass ? s1 : out_word;
    assign fifo_wr  = s1_valid && keep;
    assign drop     = s1_valid && !keep;
    assign fifo_rd  = OUT_READ && (occ != '0);

    assign OUT_EMPTY = (occ == '0);
    assign OUT_DATA  = mem[rd_ptr];

    // configuration registers; counter addresses are read-only
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            conf_en      <= 1'b0;
            conf_bypass  <= 1'b0;
            conf_tot_min <= 8'd0;
        end else if (BUS_WR) begin
            if (BUS_ADD == A_CONF) begin
                conf_en     <= BUS_DATA_IN[0];
                conf_bypass <= BUS_DATA_IN[1];
            end
            if (BUS_ADD == A_TOT)
                conf_tot_min <= BUS_DATA_IN;
        end
    end

    // register read decode
    always_comb begin
        rd_mux = 8'h00;
        unique case (1'b1)
            (BUS_ADD == A_VER):  rd_mux = VERSION;
            (BUS_ADD == A_CONF): rd_mux = {6'd0, conf_bypass, conf_en};
            (BUS_ADD == A_TOT):  rd_mux = conf_tot_min;
            (BUS_ADD == A_HITL): rd_mux = hit_cnt[7:0];
            (BUS_ADD == A_HITH): rd_mux = hit_cnt[15:8];
            (BUS_ADD == A_DROP): rd_mux = drop_cnt;
            default:             rd_mux = 8'h00;
        endcase
    end

    // read data only moves on read strobes
    always_ff @(posedge BUS_CLK) begin
        if (rst)
            BUS_DATA_OUT <= 8'h00;
        else if (BUS_RD)
            BUS_DATA_OUT <= rd_mux;
    end

    // stage 1: capture popped word
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= IN_READ;
            if (IN_READ)
                s1 <= IN_DATA;
        end
    end

    // saturating hit / drop counters
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            hit_cnt  <= 16'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (fifo_wr && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // output FIFO storage; contents are don't-care after reset
    always_ff @(posedge BUS_CLK) begin
        if (fifo_wr)
            mem[wr_ptr] <= wr_word;
    end

    // output FIFO pointers and occupancy
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (fifo_rd)
                rd_ptr <= rd_ptr + AW'(1);
            if (fifo_wr && !fifo_rd)
                occ <= occ + OW'(1);
            else if (!fifo_wr && fifo_rd)
                occ <= occ - OW'(1);
        end
    end

endmodule

// File: tb/tb_mono_hit_proc.sv
// tb_mono_hit_proc: directed bench for mono_hit_proc
// Upstream FIFO modelled by a queue, popped on IN_READ
module tb_mono_hit_proc;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic [15:0] BUS_ADD;
    logic [7:0]  BUS_DATA_IN;
    logic        BUS_WR;
    logic        BUS_RD;
    logic [7:0]  BUS_DATA_OUT;
    logic [31:0] IN_DATA;
    logic        IN_EMPTY;
    logic        IN_READ;
    logic [31:0] OUT_DATA;
    logic        OUT_EMPTY;
    logic        OUT_READ;

    logic [31:0] up_q[$];
    logic [31:0] exp_q[$];
    logic        rd_pending;
    logic [7:0]  rdat;
    int          n_chk = 0;
    int          n_pass = 0;
    int          k;

    always #5 BUS_CLK = ~BUS_CLK;

    mono_hit_proc #(.OUT_DEPTH(8), .ABUSWIDTH(16)) dut (
        .BUS_CLK      (BUS_CLK),
        .BUS_RST      (BUS_RST),
        .BUS_ADD      (BUS_ADD),
        .BUS_DATA_IN  (BUS_DATA_IN),
        .BUS_WR       (BUS_WR),
        .BUS_RD       (BUS_RD),
        .BUS_DATA_OUT (BUS_DATA_OUT),
        .IN_DATA      (IN_DATA),
        .IN_EMPTY     (IN_EMPTY),
        .IN_READ      (IN_READ),
        .OUT_DATA     (OUT_DATA),
        .OUT_EMPTY    (OUT_EMPTY),
        .OUT_READ     (OUT_READ)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h",
                    tag, obs, exp);
    endtask

    task automatic drive_up();
        IN_EMPTY = (up_q.size() == 0);
        IN_DATA  = IN_EMPTY ? 32'h0 : up_q[0];
    endtask

    task automatic push(input logic [31:0] w);
        up_q.push_back(w);
        drive_up();
    endtask

    // one clock; pops the upstream queue if IN_READ was high before the edge
    task automatic cyc();
        #1;
        rd_pending = IN_READ;
        @(posedge BUS_CLK);
        #1;
        if (rd_pending && up_q.size() > 0)
            void'(up_q.pop_front());
        drive_up();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        BUS_ADD     = a;
        BUS_DATA_IN = d;
        BUS_WR      = 1'b1;
        cyc();
        BUS_WR      = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        BUS_ADD = a;
        BUS_RD  = 1'b1;
        cyc();
        BUS_RD  = 1'b0;
        d       = BUS_DATA_OUT;
    endtask

    task automatic out_pop();
        OUT_READ = 1'b1;
        cyc();
        OUT_READ = 1'b0;
    endtask

    initial begin
        BUS_RST     = 1'b1;
        BUS_ADD     = 16'd0;
        BUS_DATA_IN = 8'd0;
        BUS_WR      = 1'b0;
        BUS_RD      = 1'b0;
        OUT_READ    = 1'b0;
        drive_up();
        @(posedge BUS_CLK);
        #1;
        push(32'hDEAD_BEEF);
        cyc();
        cyc();
        chk("rst_in_read", 32'(IN_READ), 32'd0);
        BUS_RST = 1'b0;
        up_q.delete();
        drive_up();
        cyc();
        chk("rst_out_empty", 32'(OUT_EMPTY), 32'd1);
        chk("rst_bus_out", 32'(BUS_DATA_OUT), 32'd0);
        chk("rst_in_read_en0", 32'(IN_READ), 32'd0);

        // basic pass with latency
        bus_write(16'd2, 8'h01);
        push({2'b01, 8'd10, 8'd25, 8'd3, 6'd5});
        #1;
        chk("lat_in_read", 32'(IN_READ), 32'd1);
        cyc();
        chk("lat_n1_empty", 32'(OUT_EMPTY), 32'd1);
        cyc();
        chk("lat_n2_empty", 32'(OUT_EMPTY), 32'd0);
        chk("basic_data", OUT_DATA, {2'b01, 8'd10, 8'd15, 8'd3, 6'd5});
        out_pop();
        chk("last_pop_empty", 32'(OUT_EMPTY), 32'd1);
        bus_read(16'd4, rdat);
        chk("hit_lo_1", 32'(rdat), 32'd1);
        bus_read(16'd5, rdat);
        chk("hit_hi_1", 32'(rdat), 32'd0);

        // wrap-around tot = 10, dropped at min 11, kept at min 10
        bus_write(16'd3, 8'd11);
        push({2'b10, 8'd250, 8'd4, 8'd7, 6'd9});
        cyc();
        cyc();
        cyc();
        chk("wrap_drop_empty", 32'(OUT_EMPTY), 32'd1);
        bus_read(16'd6, rdat);
        chk("drop_cnt_1", 32'(rdat), 32'd1);
        bus_write(16'd3, 8'd10);
        push({2'b10, 8'd250, 8'd4, 8'd7, 6'd9});
        cyc();
        cyc();
        cyc();
        chk("wrap_keep", OUT_DATA, {2'b10, 8'd250, 8'd10, 8'd7, 6'd9});
        out_pop();

        // back-pressure: 20 words, no reads
        bus_write(16'd3, 8'd0);
        for (int i = 0; i < 20; i++) begin
            up_q.push_back({2'b11, 8'(i), 8'(i + 5), 8'(i), 6'(i)});
            exp_q.push_back({2'b11, 8'(i), 8'd5, 8'(i), 6'(i)});
        end
        drive_up();
        repeat (15) cyc();
        chk("bp_in_read", 32'(IN_READ), 32'd0);
        chk("bp_popped", 32'(up_q.size()), 32'd12);
        chk("bp_full_nonempty", 32'(OUT_EMPTY), 32'd0);
        OUT_READ = 1'b1;
        k = 0;
        for (int c = 0; c < 100 && k < 20; c++) begin
            #1;
            if (!OUT_EMPTY) begin
                chk($sformatf("bp_word%0d", k), OUT_DATA, exp_q[k]);
                k++;
            end
            cyc();
        end
        OUT_READ = 1'b0;
        chk("bp_count", 32'(k), 32'd20);
        chk("bp_drained", 32'(OUT_EMPTY), 32'd1);
        bus_read(16'd4, rdat);
        chk("hit_lo_22", 32'(rdat), 32'd22);

        // bypass passes the word bit-exact
        bus_write(16'd2, 8'h03);
        bus_write(16'd3, 8'd255);
        push({2'b00, 8'd77, 8'd77, 8'd1, 6'd2});
        cyc();
        cyc();
        cyc();
        chk("byp_empty", 32'(OUT_EMPTY), 32'd0);
        chk("byp_data", OUT_DATA, {2'b00, 8'd77, 8'd77, 8'd1, 6'd2});
        out_pop();
        bus_read(16'd4, rdat);
        chk("hit_lo_23", 32'(rdat), 32'd23);
        bus_write(16'd2, 8'h01);
        bus_write(16'd3, 8'd0);

        // soft reset with 3 buffered and s1 valid
        for (int i = 0; i < 5; i++)
            up_q.push_back({2'b01, 8'd0, 8'd9, 8'(i), 6'(i)});
        drive_up();
        repeat (4) cyc();
        chk("sr_pre_nonempty", 32'(OUT_EMPTY), 32'd0);
        chk("sr_pre_popped", 32'(up_q.size()), 32'd1);
        BUS_ADD = 16'd0;
        BUS_WR  = 1'b1;
        #1;
        chk("sr_in_read_rst", 32'(IN_READ), 32'd0);
        cyc();
        BUS_WR = 1'b0;
        chk("sr_out_empty", 32'(OUT_EMPTY), 32'd1);
        chk("sr_in_read", 32'(IN_READ), 32'd0);
        bus_read(16'd4, rdat);
        chk("sr_hit_lo", 32'(rdat), 32'd0);
        bus_read(16'd2, rdat);
        chk("sr_conf", 32'(rdat), 32'd0);
        up_q.delete();
        drive_up();

        // drop counter saturation
        bus_write(16'd2, 8'h01);
        bus_write(16'd3, 8'd200);
        for (int i = 0; i < 300; i++)
            up_q.push_back({2'b00, 8'd0, 8'd0, 8'(i), 6'(i)});
        drive_up();
        for (int c = 0; c < 400 && up_q.size() > 0; c++)
            cyc();
        repeat (3) cyc();
        chk("sat_all_popped", 32'(up_q.size()), 32'd0);
        bus_read(16'd6, rdat);
        chk("sat_drop", 32'(rdat), 32'd255);
        bus_write(16'd6, 8'd0);
        bus_read(16'd6, rdat);
        chk("drop_ro", 32'(rdat), 32'd255);
        bus_read(16'd0, rdat);
        chk("version", 32'(rdat), 32'd1);
        bus_read(16'd3, rdat);
        chk("tot_min_rb", 32'(rdat), 32'd200);
        bus_read(16'd7, rdat);
        chk("unmapped", 32'(rdat), 32'd0);
        chk("sat_out_empty", 32'(OUT_EMPTY), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mono_hit_proc.md
# mono_hit_proc

Hit post-processing stage placed directly downstream of the MONOPIX RX core's 1024-deep output FIFO. It pops decoded 32-bit hit words (identifier, LE, TE, row, column), computes time-over-threshold as TE − LE modulo 256, drops hits below a programmable ToT threshold, and counts accepted and dropped hits. Accepted hits are re-packed with ToT in place of TE and buffered in a small first-word-fall-through FIFO that feeds the readout arbiter.

## Interface
- OUT_DEPTH, 8: output FIFO depth in words; power of two, ≥ 4.
- ABUSWIDTH, 16: bus address width.
- BUS_CLK  in  1  sole clock; all logic rises on its positive edge.
- BUS_RST  in  1  synchronous, active-high reset.
- BUS_ADD  in  ABUSWIDTH  register address.
- BUS_DATA_IN  in  8  register write data.
- BUS_WR  in  1  register write strobe.
- BUS_RD  in  1  register read strobe.
- BUS_DATA_OUT  out  8  registered read data.
- IN_DATA  in  32  upstream word: [31:30] ID, [29:22] LE, [21:14] TE, [13:6] row, [5:0] col; valid while IN_EMPTY = 0.
- IN_EMPTY  in  1  upstream FIFO empty.
- IN_READ  out  1  combinational pop; consumes IN_DATA in the same cycle.
- OUT_DATA  out  32  head word of the output FIFO; valid while OUT_EMPTY = 0.
- OUT_EMPTY  out  1  output FIFO empty.
- OUT_READ  in  1  pop; ignored while OUT_EMPTY = 1.

## Operation
- Internal reset RST = BUS_RST | (BUS_WR & BUS_ADD == 0), a soft reset.
- Registers:
  - Address 0: reads VERSION = 1.
  - Address 2: [0] CONF_EN, [1] CONF_BYPASS.
  - Address 3: CONF_TOT_MIN[7:0].
  - Address 4: HIT_CNT[7:0]. Address 5: HIT_CNT[15:8].
  - Address 6: DROP_CNT[7:0].
  - Other addresses read 0.
  - Writes to addresses 4–6 are ignored.
- BUS_DATA_OUT updates only on BUS_RD cycles and holds its value otherwise.
- IN_READ = !RST & CONF_EN & !IN_EMPTY & (occ + s1_valid < OUT_DEPTH), where occ is the current output FIFO occupancy.
  - This credit rule alone prevents overflow. It holds even with zero drops and no OUT_READ.
- Stage 1: on an IN_READ edge, capture IN_DATA into s1 and set s1_valid = 1. With no IN_READ, clear s1_valid.
- Stage 2, computed from s1:
  - tot = (TE − LE) mod 256, 8-bit wrap-around.
  - Out word = {ID, LE, tot, row, col}.
  - CONF_BYPASS = 1: write s1 unchanged; no filter applied; HIT_CNT still increments.
  - CONF_BYPASS = 0 and tot < CONF_TOT_MIN: discard the word; DROP_CNT += 1, saturating at 255.
  - Otherwise: write the out word; HIT_CNT += 1, saturating at 65535.
- Output FIFO:
  - Write and OUT_READ in the same cycle leave occ unchanged.
  - occ ranges 0..OUT_DEPTH.
  - Pointers wrap modulo OUT_DEPTH.
- CONF_EN falling: IN_READ goes low immediately. A word already in s1 still completes. The output FIFO stays readable.
- CONF_TOT_MIN and CONF_BYPASS are sampled at the stage-2 edge. A change applies to the word in s1 at that edge.

## Timing
- Reset values:
  - All config registers, HIT_CNT, DROP_CNT: 0.
  - s1_valid = 0, occ = 0, OUT_EMPTY = 1.
  - IN_READ = 0 in every cycle where RST = 1.
  - BUS_DATA_OUT = 0; OUT_DATA is don't-care while OUT_EMPTY = 1.
- Reset in mid-operation: s1 and the FIFO contents are discarded. The upstream word popped in that cycle is lost; this is accepted.
- Latency: IN_READ high in cycle n → word in s1 after edge n → written at edge n+1 → OUT_EMPTY = 0 and OUT_DATA valid in cycle n+2.
- Throughput: one word per cycle while credit allows.
- Full output FIFO (occ = OUT_DEPTH): OUT_EMPTY = 0 and no writes are pending, because credit is exhausted.
- OUT_READ at occ = 1 with no write: OUT_EMPTY = 1 in the next cycle.
- Counter saturation: HIT_CNT stops at 0xFFFF, DROP_CNT at 0xFF. Both clear only on RST.

## Test plan
- Basic pass: CONF_EN = 1, CONF_TOT_MIN = 0. IN_DATA = {2'b01, LE = 8'd10, TE = 8'd25, row 8'd3, col 6'd5} → OUT_DATA = {01, 10, 15, 3, 5} two cycles after IN_READ. HIT_CNT = 1.
- Wrap-around: LE = 250, TE = 4 → tot = 10. With CONF_TOT_MIN = 11: word dropped, DROP_CNT = 1, OUT_EMPTY stays 1.
- Back-pressure: 20 words queued, OUT_READ held low → exactly OUT_DEPTH = 8 words stored and IN_READ stays low. Then OUT_READ continuous → all 20 words appear in order with no loss or duplicates.
- Bypass: CONF_BYPASS = 1, CONF_TOT_MIN = 255, tot = 0 → OUT_DATA equals IN_DATA bit-exact. HIT_CNT increments.
- Soft reset mid-stream: write address 0 with 3 words buffered and s1 valid → next cycle OUT_EMPTY = 1, IN_READ = 0, HIT_CNT = 0, CONF_EN = 0.
- Saturation: 300 dropped hits → DROP_CNT reads 255 at address 6. Bus read of address 0 → 1.
